alu_vec_driver: RTL and testbench

- Sequencing initiator for the combinational vector ALU (ALU_vec).
- Accepts one vector operation per request handshake and drives registered operands and opcode onto the ALU ports.
- Holds those values stable for a per-opcode settle count, then captures result and per-lane flags into a response register.
- Presents the response on a valid/ready interface to the vector writeback stage.

---
 rtl/alu_vec_driver.sv | 125 ++++++++++++
 tb/tb_alu_vec_driver.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_driver.sv
// alu_vec_driver: sequencing initiator for the combinational vector ALU.
// Registers operands, waits a per-opcode settle count, returns a response.
module alu_vec_driver #(
    parameter int WIDTH_V    = 128,
    parameter int BITS_INDEX = 8,
    parameter int TAG_W      = 4,
    parameter int WAIT_FAST  = 1,
    parameter int WAIT_MUL   = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [WIDTH_V-1:0]             req_a,
    input  logic [WIDTH_V-1:0]             req_b,
    input  logic [BITS_INDEX-1:0]          req_c,
    input  logic [2:0]                     req_opcode,
    input  logic                           req_flag_scalar,
    input  logic [TAG_W-1:0]               req_tag,
    output logic [WIDTH_V-1:0]             alu_a,
    output logic [WIDTH_V-1:0]             alu_b,
    output logic [BITS_INDEX-1:0]          alu_c,
    output logic [2:0]                     alu_opcode,
    output logic                           alu_flag_scalar,
    input  logic [WIDTH_V-1:0]             alu_result,
    input  logic [(WIDTH_V/BITS_INDEX)*4-1:0] alu_flags,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [WIDTH_V-1:0]             rsp_result,
    output logic [(WIDTH_V/BITS_INDEX)*4-1:0] rsp_flags,
    output logic [TAG_W-1:0]               rsp_tag,
    output logic                           rsp_err
);

    localparam int NUM_INSTANCES = WIDTH_V / BITS_INDEX;
    localparam int FLAG_W        = NUM_INSTANCES * 4;
    localparam int WAIT_MAX      = (WAIT_MUL > WAIT_FAST) ? WAIT_MUL : WAIT_FAST;
    localparam int CNT_W         = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_MUL  = CNT_W'(WAIT_MUL - 1);
    localparam logic [CNT_W-1:0] CNT_FAST = CNT_W'(WAIT_FAST - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_HOLD
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [TAG_W-1:0] r_tag;

    logic w_accept;
    logic w_legal;

    // Ready when idle, or when the held response retires this cycle.
    always_comb begin
        req_ready = (r_state == S_IDLE) ||
                    ((r_state == S_HOLD) && rsp_ready);
        w_accept  = req_valid && req_ready;
        w_legal   = (req_opcode == 3'b000) || (req_opcode == 3'b001) ||
                    (req_opcode == 3'b010) || (req_opcode == 3'b111);
    end

    // Main sequencer: accept, settle, capture, hold until drained.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_tag           <= '0;
            alu_a           <= '0;
            alu_b           <= '0;
            alu_c           <= '0;
            alu_opcode      <= '0;
            alu_flag_scalar <= 1'b0;
            rsp_valid       <= 1'b0;
            rsp_result      <= '0;
            rsp_flags       <= '0;
            rsp_tag         <= '0;
            rsp_err         <= 1'b0;
        end else if (w_accept) begin
            if (w_legal) begin
                alu_a           <= req_a;
                alu_b           <= req_b;
                alu_c           <= req_c;
                alu_opcode      <= req_opcode;
                alu_flag_scalar <= req_flag_scalar;
                r_tag           <= req_tag;
                r_cnt           <= (req_opcode == 3'b000) ? CNT_MUL : CNT_FAST;
                rsp_valid       <= 1'b0;
                r_state         <= S_DRIVE;
            end else begin
                // Illegal opcode: the ALU is never touched.
                rsp_result <= '0;
                rsp_flags  <= '0;
                rsp_tag    <= req_tag;
                rsp_err    <= 1'b1;
                rsp_valid  <= 1'b1;
                r_state    <= S_HOLD;
            end
        end else begin
            case (r_state)
                S_DRIVE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        rsp_result <= alu_result;
                        rsp_flags  <= alu_flags[FLAG_W-1:0];
                        rsp_tag    <= r_tag;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= 1'b1;
                        r_state    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_vec_driver.sv
// tb_alu_vec_driver: table vectors, directed corner sequences and a
// randomized run against a transaction-level reference model.
module tb_alu_vec_driver;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_a, req_b;
    logic [7:0]   req_c;
    logic [2:0]   req_opcode;
    logic         req_flag_scalar;
    logic [3:0]   req_tag;
    logic [127:0] alu_a, alu_b;
    logic [7:0]   alu_c;
    logic [2:0]   alu_opcode;
    logic         alu_flag_scalar;
    logic [127:0] alu_result;
    logic [63:0]  alu_flags;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_result;
    logic [63:0]  rsp_flags;
    logic [3:0]   rsp_tag;
    logic         rsp_err;

    always #5 clk = ~clk;

    alu_vec_driver dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .req_opcode(req_opcode), .req_flag_scalar(req_flag_scalar),
        .req_tag(req_tag),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .alu_opcode(alu_opcode), .alu_flag_scalar(alu_flag_scalar),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags),
        .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    // Lane-wise vector ALU behaviour (stands in for ALU_vec).
    function automatic logic [127:0] ref_res(input logic [127:0] a,
            input logic [127:0] b, input logic [7:0] c, input logic [2:0] op);
        logic [127:0] r;
        logic [7:0] x, y;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            x = a[i*8 +: 8];
            y = b[i*8 +: 8];
            case (op)
                3'b000:  r[i*8 +: 8] = x * y;
                3'b001:  r[i*8 +: 8] = x - y;
                3'b010:  r[i*8 +: 8] = x + y;
                3'b111:  r[i*8 +: 8] = c;
                default: r[i*8 +: 8] = 8'h00;
            endcase
        end
        return r;
    endfunction

    function automatic logic [63:0] ref_flags(input logic [127:0] r,
            input logic fs);
        logic [63:0] f;
        logic [7:0] l;
        f = '0;
        for (int i = 0; i < 16; i++) begin
            l = r[i*8 +: 8];
            f[i*4 +: 4] = {l == 8'h00, l[7], ^l, fs};
        end
        return f;
    endfunction

    assign alu_result = ref_res(alu_a, alu_b, alu_c, alu_opcode);
    assign alu_flags  = ref_flags(alu_result, alu_flag_scalar);

    function automatic logic [127:0] bc(input logic [7:0] v);
        return {16{v}};
    endfunction

    function automatic bit legal(input logic [2:0] op);
        return (op == 3'b000) || (op == 3'b001) ||
               (op == 3'b010) || (op == 3'b111);
    endfunction

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic [7:0]   c;
        logic [2:0]   op;
        logic         fs;
        logic [3:0]   tag;
        logic [127:0] exp_res;
        logic         exp_err;
        int           exp_lat;
    } vec_t;

    typedef struct {
        logic [127:0] res;
        logic [63:0]  flags;
        logic [3:0]   tag;
        logic         err;
        int           lat;
        int           acc;
    } exp_t;

    function automatic vec_t mk(input logic [127:0] a, input logic [127:0] b,
            input logic [7:0] c, input logic [2:0] op, input logic fs,
            input logic [3:0] tag, input logic [127:0] er, input logic ee,
            input int el);
        vec_t v;
        v.a = a; v.b = b; v.c = c; v.op = op; v.fs = fs; v.tag = tag;
        v.exp_res = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
            input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic send(input vec_t v);
        bit ok;
        ok = 0;
        req_a = v.a; req_b = v.b; req_c = v.c;
        req_opcode = v.op; req_flag_scalar = v.fs; req_tag = v.tag;
        req_valid = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            if (req_ready) ok = 1;
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    // Latency counted in rising edges from accept edge to sampling edge.
    task automatic wait_valid(input int maxc, output int lat);
        lat = -1;
        for (int n = 0; n < maxc; n++) begin
            if (rsp_valid) begin
                lat = n + 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    vec_t tbl[8];
    vec_t v;
    exp_t q[$];
    exp_t e;
    int lat;
    logic [127:0] last_a;
    logic [2:0]   last_op;

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0; req_opcode = '0;
        req_flag_scalar = 1'b0; req_tag = '0;
        last_a = '0; last_op = '0;

        tbl[0] = mk(bc(10),  bc(20),  8'd0,  3'b010, 1'b0, 4'h1, bc(30), 1'b0, 2);
        tbl[1] = mk(bc(5),   bc(6),   8'd0,  3'b000, 1'b0, 4'h2, bc(30), 1'b0, 3);
        tbl[2] = mk(bc(1),   bc(2),   8'd42, 3'b111, 1'b0, 4'h3, bc(42), 1'b0, 2);
        tbl[3] = mk(bc(50),  bc(20),  8'd0,  3'b001, 1'b1, 4'h4, bc(30), 1'b0, 2);
        tbl[4] = mk(bc(3),   bc(4),   8'd9,  3'b100, 1'b1, 4'hA, '0,     1'b1, 1);
        tbl[5] = mk(bc(200), bc(100), 8'd0,  3'b010, 1'b1, 4'h5, bc(44), 1'b0, 2);
        tbl[6] = mk(bc(7),   bc(8),   8'd0,  3'b011, 1'b0, 4'hF, '0,     1'b1, 1);
        tbl[7] = mk(bc(16),  bc(16),  8'd0,  3'b000, 1'b0, 4'h6, bc(0),  1'b0, 3);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_result", rsp_result, 0);
        chk("rst_req_ready", req_ready, 1);
        @(negedge clk);

        // Table vectors, downstream always ready.
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i]);
            wait_valid(8, lat);
            chk($sformatf("t%0d_lat", i), lat, tbl[i].exp_lat);
            chk($sformatf("t%0d_res", i), rsp_result, tbl[i].exp_res);
            chk($sformatf("t%0d_flags", i), rsp_flags,
                tbl[i].exp_err ? 64'h0 : ref_flags(tbl[i].exp_res, tbl[i].fs));
            chk($sformatf("t%0d_err", i), rsp_err, tbl[i].exp_err);
            chk($sformatf("t%0d_tag", i), rsp_tag, tbl[i].tag);
            if (tbl[i].exp_err) begin
                chk($sformatf("t%0d_alu_a_kept", i), alu_a, last_a);
                chk($sformatf("t%0d_alu_op_kept", i), alu_opcode, last_op);
            end else begin
                last_a = tbl[i].a;
                last_op = tbl[i].op;
            end
            @(negedge clk);
        end

        // Mul: ALU inputs stable through the settle window.
        v = mk(bc(7), bc(9), 8'd0, 3'b000, 1'b0, 4'h2, bc(63), 1'b0, 3);
        send(v);
        for (int n = 0; n < 2; n++) begin
            chk("mul_drive_a", alu_a, bc(7));
            chk("mul_drive_b", alu_b, bc(9));
            chk("mul_drive_op", alu_opcode, 3'b000);
            chk("mul_drive_valid", rsp_valid, 0);
            @(negedge clk);
        end
        chk("mul_valid", rsp_valid, 1);
        chk("mul_res", rsp_result, bc(63));
        @(negedge clk);

        // Set under 5 cycles of backpressure, then back-to-back sub.
        rsp_ready = 1'b0;
        v = mk('0, '0, 8'd42, 3'b111, 1'b0, 4'h7, bc(42), 1'b0, 2);
        send(v);
        wait_valid(8, lat);
        chk("set_lat", lat, 2);
        req_a = bc(50); req_b = bc(20); req_c = 8'd0; req_opcode = 3'b001;
        req_flag_scalar = 1'b0; req_tag = 4'h8; req_valid = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1;
            chk("stall_res", rsp_result, bc(42));
            chk("stall_valid", rsp_valid, 1);
            chk("stall_req_ready", req_ready, 0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        chk("handoff_req_ready", req_ready, 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("handoff_valid_drop", rsp_valid, 0);
        wait_valid(8, lat);
        chk("b2b_sub_lat", lat, 2);
        chk("b2b_sub_res", rsp_result, bc(30));
        chk("b2b_sub_tag", rsp_tag, 4'h8);

        // Illegal accepted in the same edge the sub response retires.
        v = mk(bc(1), bc(1), 8'd1, 3'b100, 1'b0, 4'hA, '0, 1'b1, 1);
        send(v);
        chk("ill_valid", rsp_valid, 1);
        chk("ill_err", rsp_err, 1);
        chk("ill_res", rsp_result, 0);
        chk("ill_flags", rsp_flags, 0);
        chk("ill_tag", rsp_tag, 4'hA);
        chk("ill_alu_a", alu_a, bc(50));
        chk("ill_alu_b", alu_b, bc(20));
        chk("ill_alu_op", alu_opcode, 3'b001);
        @(negedge clk);

        // Reset during the first DRIVE cycle of a mul.
        v = mk(bc(3), bc(3), 8'd5, 3'b000, 1'b1, 4'hC, bc(9), 1'b0, 3);
        send(v);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rmid_valid", rsp_valid, 0);
        chk("rmid_alu_a", alu_a, 0);
        chk("rmid_alu_c", alu_c, 0);
        chk("rmid_alu_op", alu_opcode, 0);
        chk("rmid_alu_fs", alu_flag_scalar, 0);
        chk("rmid_req_ready", req_ready, 1);
        begin
            bit seen;
            seen = 0;
            for (int n = 0; n < 6; n++) begin
                @(negedge clk);
                if (rsp_valid) seen = 1;
            end
            chk("rmid_no_rsp", seen, 0);
        end

        // Randomized traffic with random backpressure.
        begin
            int cyc, sent;
            bit holding, seen, stall;
            logic [127:0] p_res;
            logic [63:0]  p_flags;
            logic [3:0]   p_tag;
            logic         p_err;
            logic [2:0]   legal_ops[4];
            int r;
            legal_ops[0] = 3'b000; legal_ops[1] = 3'b001;
            legal_ops[2] = 3'b010; legal_ops[3] = 3'b111;
            cyc = 0; sent = 0; holding = 0; seen = 0; stall = 0;
            p_res = '0; p_flags = '0; p_tag = '0; p_err = 1'b0;
            while ((sent < 200 || q.size() > 0) && cyc < 6000) begin
                if (stall) begin
                    chk("rnd_stall_valid", rsp_valid, 1);
                    chk("rnd_stall_res", rsp_result, p_res);
                    chk("rnd_stall_flags", rsp_flags, p_flags);
                    chk("rnd_stall_tag", rsp_tag, p_tag);
                    chk("rnd_stall_err", rsp_err, p_err);
                end
                if (rsp_valid && q.size() == 0)
                    chk("rnd_spurious_valid", rsp_valid, 0);
                if (rsp_valid && q.size() > 0 && !seen) begin
                    chk("rnd_lat", cyc - q[0].acc, q[0].lat);
                    seen = 1;
                end
                if (!holding) req_valid = 1'b0;
                rsp_ready = ($urandom_range(0, 3) != 0);
                if (!holding && sent < 200 && $urandom_range(0, 2) != 0) begin
                    r = $urandom_range(0, 9);
                    req_a = {$urandom, $urandom, $urandom, $urandom};
                    req_b = {$urandom, $urandom, $urandom, $urandom};
                    req_c = 8'($urandom);
                    req_opcode = (r < 8) ? legal_ops[r % 4]
                                         : 3'($urandom_range(3, 6));
                    req_flag_scalar = 1'($urandom);
                    req_tag = 4'($urandom);
                    req_valid = 1'b1;
                    holding = 1;
                end
                #1;
                if (rsp_valid && rsp_ready && q.size() > 0) begin
                    e = q.pop_front();
                    chk("rnd_res", rsp_result, e.res);
                    chk("rnd_flags", rsp_flags, e.flags);
                    chk("rnd_tag", rsp_tag, e.tag);
                    chk("rnd_err", rsp_err, e.err);
                    seen = 0;
                end
                if (req_valid && req_ready) begin
                    e.err = !legal(req_opcode);
                    e.res = e.err ? '0
                          : ref_res(req_a, req_b, req_c, req_opcode);
                    e.flags = e.err ? '0 : ref_flags(e.res, req_flag_scalar);
                    e.tag = req_tag;
                    e.lat = e.err ? 1 : ((req_opcode == 3'b000) ? 3 : 2);
                    e.acc = cyc;
                    q.push_back(e);
                    sent++;
                    holding = 0;
                end
                stall = rsp_valid && !rsp_ready;
                p_res = rsp_result; p_flags = rsp_flags;
                p_tag = rsp_tag; p_err = rsp_err;
                @(negedge clk);
                cyc++;
            end
            req_valid = 1'b0;
            chk("rnd_all_done", q.size(), 0);
            chk("rnd_all_sent", sent, 200);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
